// File: rtl/cpu_ctrl.sv
// cpu_ctrl: Moore controller for a simple 16-bit datapath.
//
// Holds the instruction register (IR), decodes it, and sequences the
// register-file / ALU strobes needed to execute one instruction per start.
// Supported: MOV Rn,#imm8; MOV Rd,Rm{sh}; ADD; CMP; AND; MVN Rd,Rm{sh}.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous, active-high
//   s          in   start; begins execution of IR when in WAIT
//   load       in   load 'in' into IR (honoured only in WAIT)
//   in[15:0]   in   instruction word
//   w          out  1 while in WAIT (ready)
//   halted     out  1 while in HALT (constant 0 without the macro)
//   dp_in[15:0]out  sign-extended IR[7:0], combinational from IR
//   readnum    out  register-file read address
//   writenum   out  register-file write address
//   write, vsel, asel, bsel, loada, loadb, loadc, loads
//              out  datapath strobes / selects
//   ALUop[1:0] out  00 ADD, 01 SUB, 10 AND, 11 NOT
//   shift[1:0] out  shifter code
//
// Build option
//   CPU_CTRL_ILLEGAL_TRAP_EN: an undefined op traps into HALT (held until
//   reset). Without it an undefined op is a one-cycle NOP back to WAIT.

module cpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        halted,
  output logic [15:0] dp_in,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        asel,
  output logic        bsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_IMM,
    S_WR_RD
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t      state, nxt;
  logic [15:0] ir;

  // IR fields
  logic [2:0] op, rn, rd, rm;
  logic [1:0] sub, sh;

  assign op  = ir[15:13];
  assign sub = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign sh  = ir[4:3];
  assign rm  = ir[2:0];

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  assign is_mov_imm = (op == 3'b110) && (sub == 2'b10);
  assign is_mov_reg = (op == 3'b110) && (sub == 2'b00);
  assign is_alu     = (op == 3'b101);
  assign is_cmp     = is_alu && (sub == 2'b01);
  assign is_mvn     = is_alu && (sub == 2'b11);

  assign dp_in = {{8{ir[7]}}, ir[7:0]};
  assign bsel  = 1'b0;

  // Next-state outputs. Outputs are registered, so they are derived from
  // the state being entered rather than the current one; the IR fields are
  // stable whenever a data-dependent state is entered.
  logic       n_w, n_write, n_vsel, n_asel;
  logic       n_loada, n_loadb, n_loadc, n_loads;
  logic [2:0] n_readnum, n_writenum;
  logic [1:0] n_aluop, n_shift;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic       n_halted;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      S_WAIT:   if (s) nxt = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                nxt = S_WR_IMM;
        else if (is_mov_reg || is_mvn) nxt = S_GET_B;
        else if (is_alu)               nxt = S_GET_A;
        else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          nxt = S_HALT;
`else
          nxt = S_WAIT;
`endif
        end
      end
      S_GET_A:  nxt = S_GET_B;
      S_GET_B:  nxt = S_ALU;
      S_ALU:    nxt = is_cmp ? S_WAIT : S_WR_RD;
      S_WR_IMM: nxt = S_WAIT;
      S_WR_RD:  nxt = S_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_HALT:   nxt = S_HALT;
`endif
      default:  nxt = S_WAIT;
    endcase
  end

  always_comb begin
    n_w        = 1'b0;
    n_write    = 1'b0;
    n_vsel     = 1'b0;
    n_asel     = 1'b0;
    n_loada    = 1'b0;
    n_loadb    = 1'b0;
    n_loadc    = 1'b0;
    n_loads    = 1'b0;
    n_readnum  = '0;
    n_writenum = '0;
    n_aluop    = '0;
    n_shift    = '0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    n_halted   = 1'b0;
`endif
    case (nxt)
      S_WAIT:  n_w = 1'b1;
      S_GET_A: begin
        n_readnum = rn;
        n_loada   = 1'b1;
      end
      S_GET_B: begin
        n_readnum = rm;
        n_loadb   = 1'b1;
      end
      S_ALU: begin
        n_shift = sh;
        n_aluop = is_alu ? sub : 2'b00;
        n_asel  = is_mov_reg;
        // CMP only updates the status register; the result is discarded.
        n_loads = is_cmp;
        n_loadc = !is_cmp;
      end
      S_WR_RD: begin
        n_writenum = rd;
        n_write    = 1'b1;
      end
      S_WR_IMM: begin
        n_writenum = rn;
        n_vsel     = 1'b1;
        n_write    = 1'b1;
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_HALT:  n_halted = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      write    <= 1'b0;
      vsel     <= 1'b0;
      asel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      ALUop    <= '0;
      shift    <= '0;
    end else begin
      state    <= nxt;
      if ((state == S_WAIT) && load) ir <= in;
      w        <= n_w;
      write    <= n_write;
      vsel     <= n_vsel;
      asel     <= n_asel;
      loada    <= n_loada;
      loadb    <= n_loadb;
      loadc    <= n_loadc;
      loads    <= n_loads;
      readnum  <= n_readnum;
      writenum <= n_writenum;
      ALUop    <= n_aluop;
      shift    <= n_shift;
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) halted <= 1'b0;
    else       halted <= n_halted;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: expected per-cycle output vectors are queued
// as stimulus is applied and compared after each clock edge.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, halted;
  logic [15:0] dp_in;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, asel, bsel, loada, loadb, loadc, loads;
  logic [1:0]  ALUop, shift;

  cpu_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .halted(halted), .dp_in(dp_in),
    .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .asel(asel), .bsel(bsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .ALUop(ALUop), .shift(shift)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic        halted;
    logic [15:0] dp;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        write, vsel, asel, bsel, loada, loadb, loadc, loads;
    logic [1:0]  aluop;
    logic [1:0]  shift;
  } obs_t;

  obs_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t observe();
    obs_t v;
    v.w = w; v.halted = halted; v.dp = dp_in;
    v.rn = readnum; v.wn = writenum;
    v.write = write; v.vsel = vsel; v.asel = asel; v.bsel = bsel;
    v.loada = loada; v.loadb = loadb; v.loadc = loadc; v.loads = loads;
    v.aluop = ALUop; v.shift = shift;
    return v;
  endfunction

  function automatic obs_t base(input logic [15:0] dp);
    obs_t v;
    v = '0;
    v.dp = dp;
    return v;
  endfunction

  function automatic logic [15:0] sext(input logic [15:0] word);
    return {{8{word[7]}}, word[7:0]};
  endfunction

  task automatic push_wait(input logic [15:0] dp);
    obs_t v;
    v = base(dp);
    v.w = 1'b1;
    q.push_back(v);
  endtask

  task automatic check(input string tag);
    obs_t got, exp;
    got = observe();
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s got=%h required=<scoreboard entry>", tag, got);
    end else begin
      exp = q.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s got=%h required=%h", tag, got, exp);
      end
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then compare.
  task automatic step(input logic r, input logic sv, input logic ld,
                      input logic [15:0] word, input string tag);
    reset = r; s = sv; load = ld; in = word;
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  // Execute one defined instruction; with noise, s/load/in are wiggled while
  // busy and must have no effect.
  task automatic exec(input logic [15:0] word, input logic noise, input string tag);
    logic [2:0]  op, rn, rd, rm;
    logic [1:0]  sub, sh;
    logic [15:0] dp;
    logic        imm, mreg, alu, cmp, mvn;
    obs_t        v;
    op = word[15:13]; sub = word[12:11]; rn = word[10:8];
    rd = word[7:5];   sh = word[4:3];    rm = word[2:0];
    dp = sext(word);
    imm  = (op == 3'b110) && (sub == 2'b10);
    mreg = (op == 3'b110) && (sub == 2'b00);
    alu  = (op == 3'b101);
    cmp  = alu && (sub == 2'b01);
    mvn  = alu && (sub == 2'b11);

    q.push_back(base(dp));
    step(1'b0, 1'b1, 1'b1, word, {tag, "_decode"});
    if (imm) begin
      v = base(dp); v.wn = rn; v.vsel = 1'b1; v.write = 1'b1;
      q.push_back(v);
      step(1'b0, noise, noise, ~word, {tag, "_wr_imm"});
    end else begin
      if (!(mreg || mvn)) begin
        v = base(dp); v.rn = rn; v.loada = 1'b1;
        q.push_back(v);
        step(1'b0, noise, noise, ~word, {tag, "_get_a"});
      end
      v = base(dp); v.rn = rm; v.loadb = 1'b1;
      q.push_back(v);
      step(1'b0, noise, noise, ~word, {tag, "_get_b"});
      v = base(dp); v.shift = sh; v.aluop = alu ? sub : 2'b00; v.asel = mreg;
      if (cmp) v.loads = 1'b1; else v.loadc = 1'b1;
      q.push_back(v);
      step(1'b0, noise, noise, ~word, {tag, "_alu"});
      if (!cmp) begin
        v = base(dp); v.wn = rd; v.write = 1'b1;
        q.push_back(v);
        step(1'b0, noise, noise, ~word, {tag, "_wr_rd"});
      end
    end
    push_wait(dp);
    step(1'b0, 1'b0, 1'b0, ~word, {tag, "_done"});
  endtask

  // Count rising edges after the start edge until w returns, bounded.
  task automatic latency(input logic [15:0] word, input int exp_lat, input string tag);
    int n;
    reset = 1'b0; s = 1'b1; load = 1'b1; in = word;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0; load = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (w === 1'b1) break;
    end
    checks++;
    assert (n === exp_lat && w === 1'b1) else begin
      errors++;
      $error("FAIL %s got=%0d cycles (w=%b) required=%0d cycles", tag, n, w, exp_lat);
    end
  endtask

  initial begin
    obs_t v;
    reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;

    // Reset overrides simultaneous start and load.
    push_wait(16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'hD107, "reset_override");
    push_wait(16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, "reset_hold");
    push_wait(16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'hD107, "idle_no_load");

    exec(16'hD107, 1'b0, "mov_imm7");
    exec(16'hD2FF, 1'b1, "mov_imm_m1");
    exec(16'hA162, 1'b0, "add");
    exec(16'hA90A, 1'b1, "cmp");
    exec(16'hC0B1, 1'b0, "mov_reg");
    exec(16'hB4DF, 1'b1, "and");
    exec(16'hB84B, 1'b0, "mvn");

    latency(16'hD107, 2, "lat_mov_imm");
    latency(16'hC0B1, 4, "lat_mov_reg");
    latency(16'hB84B, 4, "lat_mvn");
    latency(16'hA90A, 4, "lat_cmp");
    latency(16'hA162, 5, "lat_add");
    latency(16'hB4DF, 5, "lat_and");

    // Reset in GET_B of an ADD aborts it; no write afterwards.
    q.push_back(base(16'h0062));
    step(1'b0, 1'b1, 1'b1, 16'hA162, "abort_decode");
    v = base(16'h0062); v.rn = 3'd1; v.loada = 1'b1;
    q.push_back(v);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "abort_get_a");
    v = base(16'h0062); v.rn = 3'd2; v.loadb = 1'b1;
    q.push_back(v);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "abort_get_b");
    push_wait(16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, "abort_reset");
    for (int i = 0; i < 3; i++) begin
      push_wait(16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000, "abort_after");
    end

    // Undefined op.
    q.push_back(base(16'h0000));
    step(1'b0, 1'b1, 1'b1, 16'hE000, "undef_decode");
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      v = base(16'h0000); v.halted = 1'b1;
      q.push_back(v);
      step(1'b0, 1'b1, 1'b1, 16'hD107, "halt_held");
    end
    push_wait(16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, "halt_reset");
    push_wait(16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "halt_cleared");
`else
    push_wait(16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "undef_nop");
    push_wait(16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, "undef_idle");
    latency(16'hE000, 1, "lat_undef");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high; sampled on clk rise.
REQ-004 s  in  1  start; begins execution of IR when in WAIT.
REQ-005 load  in  1  load instruction word into IR.
REQ-006 in  in  16  instruction word.
REQ-007 w  out  1  1 while in WAIT (ready).
REQ-008 halted  out  1  1 while in HALT; tied 0 without the macro.
REQ-009 dp_in  out  16  sign-extended IR[7:0], combinational from IR.
REQ-010 readnum, writenum  out  3 each  register-file addresses.
REQ-011 write, vsel, asel, bsel, loada, loadb, loadc, loads  out  1 each  datapath strobes and selects.
REQ-012 ALUop, shift  out  2 each  ALU op (00 ADD, 01 SUB, 10 AND, 11 NOT); shift code.

Function
REQ-013 SHALL hold a 16-bit IR; load=1 in WAIT writes in->IR at the clock edge; load is ignored in every other state.
REQ-014 SHALL decode IR fields: op=IR[15:13], sub=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-015 SHALL support: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN Rd,Rm{sh}.
REQ-016 SHALL be a Moore FSM with states WAIT, DECODE, GET_A, GET_B, ALU, WR_IMM, WR_RD, and HALT when the macro is defined.
REQ-017 WAIT: s=1 -> DECODE; otherwise stay in WAIT. DECODE uses the IR value after the edge, so load and s together execute the new word.
REQ-018 DECODE transitions: MOV imm -> WR_IMM; MOV reg and MVN -> GET_B; ADD, CMP and AND -> GET_A; undefined op -> see REQ-029.
REQ-019 GET_A: readnum=Rn, loada=1 -> GET_B. GET_B: readnum=Rm, loadb=1 -> ALU.
REQ-020 ALU: loadc=1; shift=sh; ALUop=sub for op 101 and 00 for MOV reg; asel=1 only for MOV reg. CMP: loads=1, loadc=0, next state WAIT. All other ops -> WR_RD.
REQ-021 WR_RD: writenum=Rd, vsel=0, write=1 -> WAIT. WR_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
REQ-022 Outside the states named above, every strobe (write, loada, loadb, loadc, loads) and asel, bsel, vsel, shift and ALUop SHALL be 0; bsel is always 0. readnum and writenum are 0 when unused.
REQ-023 Latency in clocks after the s edge until w=1: MOV imm 2; MOV reg, MVN and CMP 4; ADD and AND 5.
REQ-024 s while not in WAIT SHALL be ignored; no queuing.
REQ-025 At most one strobe among write, loada, loadb and loadc SHALL be high in any cycle; loads is high only together with CMP's ALU cycle.

Reset
REQ-026 reset=1 SHALL force WAIT and IR=0 at the edge, overriding s and load in the same cycle.
REQ-027 During and after reset, every output SHALL be at its WAIT value: w=1, halted=0, all strobes 0, dp_in=0.
REQ-028 Reset mid-instruction SHALL abort it; no write is issued in the reset cycle or afterwards for the aborted instruction.

Configuration
REQ-029 Macro CPU_CTRL_ILLEGAL_TRAP_EN. Defined: an undefined op in DECODE -> HALT, with halted=1, w=0 and all strobes 0, held until reset. Undefined: an undefined op in DECODE -> WAIT as a one-cycle NOP, with halted constant 0.

Verification
REQ-030 Reset, then load in=0xD107 (MOV R1,#7) and s -> write=1, writenum=1, vsel=1, dp_in=0x0007 in cycle 2; w=1 in cycle 3.
REQ-031 in=0xD2FF (MOV R2,#-1) -> dp_in=0xFFFF.
REQ-032 in=0xA162 (ADD R3,R1,R2) -> readnum sequence 1 then 2 in GET_A then GET_B; loadc with ALUop=00; write with writenum=3; w returns after 5 cycles.
REQ-033 in=0xA90A (CMP R1,R2, sh=01) -> loads=1 and shift=01 in the ALU cycle; write never asserted; 4 cycles.
REQ-034 Assert reset in GET_B of an ADD -> next cycle w=1; write stays 0 thereafter until a new s.
REQ-035 in=0xE000 with the macro defined -> halted=1 and w=0, s ignored, cleared only by reset; without the macro -> w=1 after 1 cycle.
